// File: rtl/la_obuf_seq.sv
// Output buffer front-end: registered pad data plus an enable sequencer that keeps
// pads tristated for a settle window around every enable and drive reconfiguration.
module la_obuf_seq #(
    parameter     PROP   = "DEFAULT",
    parameter int N      = 8,
    parameter int CFGW   = 4,
    parameter int CFGRST = 0,
    parameter int SETTLE = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in,
    input  logic            oe,
    input  logic [CFGW-1:0] cfg,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    output logic [N-1:0]    z,
    output logic [N-1:0]    zoe,
    output logic [CFGW-1:0] zcfg,
    output logic            busy
);

    localparam int            CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CFGW-1:0] CFGRST_C = CFGW'(CFGRST);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PRE  = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CFGW-1:0] zcfg_reg, zcfg_next;
    logic [CFGW-1:0] pend_reg, pend_next;
    logic [N-1:0]    z_reg;
    logic            drive_reg, drive_next;

    // The pad library consumes PROP; the RTL has no behaviour tied to it.
    if (PROP == "DEFAULT") begin : g_prop_default
    end else begin : g_prop_custom
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
            zcfg_reg  <= CFGRST_C;
            pend_reg  <= CFGRST_C;
            z_reg     <= '0;
            drive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            zcfg_reg  <= zcfg_next;
            pend_reg  <= pend_next;
            z_reg     <= in;
            drive_reg <= drive_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        zcfg_next  = zcfg_reg;
        pend_next  = pend_reg;
        unique case (state_reg)
            OFF: begin
                if (cfg_valid)
                    zcfg_next = cfg;
                if (oe) begin
                    state_next = PRE;
                    cnt_next   = SETTLE_C;
                end
            end
            PRE: begin
                if (!oe) begin
                    state_next = OFF;
                    cnt_next   = '0;
                end else if (cnt_reg <= ONE_C) begin
                    state_next = ON;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - ONE_C;
                end
            end
            ON: begin
                if (!oe) begin
                    state_next = OFF;
                end else if (cfg_valid) begin
                    state_next = HOLD;
                    pend_next  = cfg;
                end
            end
            HOLD: begin
                // Pads were released on the previous edge, so the new drive word is safe now.
                zcfg_next  = pend_reg;
                state_next = PRE;
                cnt_next   = SETTLE_C;
            end
            default: begin
                state_next = OFF;
                cnt_next   = '0;
            end
        endcase
    end

    // Enable is registered from the next state so zoe comes straight off a flop.
    assign drive_next = (state_next == ON);

    assign cfg_ready = (state_reg == OFF) | ((state_reg == ON) & oe);
    assign busy      = (state_reg == PRE) | (state_reg == HOLD);
    assign z         = z_reg;
    assign zcfg      = zcfg_reg;

    for (genvar gi = 0; gi < N; gi++) begin : g_zoe
        assign zoe[gi] = drive_reg;
    end

endmodule

// File: tb/tb_la_obuf_seq.sv
// Bench for la_obuf_seq: directed vector table, async-reset sequence, then random
// stimulus checked against a cycle-count reference model.
module tb_la_obuf_seq;

    localparam int N      = 8;
    localparam int CFGW   = 4;
    localparam int CFGRST = 0;
    localparam int SETTLE = 4;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    din;
    logic            oe;
    logic [CFGW-1:0] cfg;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [N-1:0]    z;
    logic [N-1:0]    zoe;
    logic [CFGW-1:0] zcfg;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    la_obuf_seq #(
        .PROP("DEFAULT"), .N(N), .CFGW(CFGW), .CFGRST(CFGRST), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .nreset(nreset), .in(din), .oe(oe), .cfg(cfg),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .z(z), .zoe(zoe),
        .zcfg(zcfg), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: "active" once an enable has been accepted, "wait_left" counts
    // edges still to go before drive, "hold" marks the one-cycle reconfiguration gap.
    bit              m_active;
    int              m_wait;
    bit              m_hold;
    logic [CFGW-1:0] m_zcfg;
    logic [CFGW-1:0] m_pend;
    logic [N-1:0]    m_z;

    function automatic bit m_driving();
        return m_active && !m_hold && (m_wait == 0);
    endfunction

    function automatic bit m_ready(input bit o);
        return !m_active || (m_driving() && o);
    endfunction

    function automatic bit m_busy();
        return m_active && !m_driving();
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_wait   = 0;
        m_hold   = 0;
        m_zcfg   = CFGW'(CFGRST);
        m_pend   = CFGW'(CFGRST);
        m_z      = '0;
    endtask

    task automatic model_step(input logic [N-1:0] d, input bit o,
                              input logic [CFGW-1:0] c, input bit v);
        m_z = d;
        if (m_hold) begin
            m_zcfg = m_pend;
            m_hold = 0;
            m_wait = SETTLE;
        end else if (!m_active) begin
            if (v) m_zcfg = c;
            if (o) begin
                m_active = 1;
                m_wait   = SETTLE;
            end
        end else if (!o) begin
            m_active = 0;
            m_wait   = 0;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end else if (v) begin
            m_hold = 1;
            m_pend = c;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    logic ready_seen;
    bit   ready_model;

    // One clock of stimulus: cfg_ready sampled mid-cycle, outputs sampled 1 after the edge.
    task automatic drive_cycle(input logic [N-1:0] d, input bit o,
                               input logic [CFGW-1:0] c, input bit v);
        logic            prev_zoe;
        logic [CFGW-1:0] prev_zcfg;
        din = d; oe = o; cfg = c; cfg_valid = v;
        @(negedge clk);
        ready_seen  = cfg_ready;
        ready_model = m_ready(o);
        prev_zoe    = zoe[0];
        prev_zcfg   = zcfg;
        @(posedge clk);
        model_step(d, o, c, v);
        #1;
        if (zcfg !== prev_zcfg)
            chk("order_zcfg_vs_zoe", {30'd0, zoe[0], prev_zoe}, 32'd0);
    endtask

    typedef struct {
        logic [N-1:0]    d;
        logic            o;
        logic [CFGW-1:0] c;
        logic            v;
        logic            rdy;
        logic [N-1:0]    e_zoe;
        logic [CFGW-1:0] e_zcfg;
        logic            e_busy;
    } vec_t;

    vec_t vecs[29];

    task automatic setv(input int i, input logic [N-1:0] d, input logic o,
                        input logic [CFGW-1:0] c, input logic v, input logic rdy,
                        input logic [N-1:0] ez, input logic [CFGW-1:0] ec, input logic eb);
        vecs[i] = '{d, o, c, v, rdy, ez, ec, eb};
    endtask

    initial begin
        // Enable from reset: drive after 4 edges, busy for those 4 cycles
        setv(0,  8'hA5, 1, 4'h0, 0, 1, 8'h00, 4'h0, 1);
        setv(1,  8'h11, 1, 4'h0, 0, 0, 8'h00, 4'h0, 1);
        setv(2,  8'h22, 1, 4'h0, 0, 0, 8'h00, 4'h0, 1);
        setv(3,  8'h33, 1, 4'h0, 0, 0, 8'h00, 4'h0, 1);
        setv(4,  8'h44, 1, 4'h0, 0, 0, 8'hFF, 4'h0, 0);
        // Drop oe, then configure while OFF
        setv(5,  8'h3C, 0, 4'h0, 0, 0, 8'h00, 4'h0, 0);
        setv(6,  8'hC3, 0, 4'h9, 1, 1, 8'h00, 4'h9, 0);
        setv(7,  8'h01, 1, 4'h0, 0, 1, 8'h00, 4'h9, 1);
        setv(8,  8'h02, 1, 4'h0, 0, 0, 8'h00, 4'h9, 1);
        setv(9,  8'h04, 1, 4'h0, 0, 0, 8'h00, 4'h9, 1);
        setv(10, 8'h08, 1, 4'h0, 0, 0, 8'h00, 4'h9, 1);
        setv(11, 8'h10, 1, 4'h0, 0, 0, 8'hFF, 4'h9, 0);
        // Reconfigure while ON at edge A
        setv(12, 8'h20, 1, 4'h3, 1, 1, 8'h00, 4'h9, 1);
        setv(13, 8'h40, 1, 4'h0, 0, 0, 8'h00, 4'h3, 1);
        setv(14, 8'h80, 1, 4'h0, 0, 0, 8'h00, 4'h3, 1);
        setv(15, 8'hFF, 1, 4'h0, 0, 0, 8'h00, 4'h3, 1);
        setv(16, 8'h00, 1, 4'h0, 0, 0, 8'h00, 4'h3, 1);
        setv(17, 8'h5A, 1, 4'h0, 0, 0, 8'hFF, 4'h3, 0);
        // oe=0 with cfg_valid in ON: oe wins, cfg taken next cycle in OFF
        setv(18, 8'h6B, 0, 4'h5, 1, 0, 8'h00, 4'h3, 0);
        setv(19, 8'h7C, 0, 4'h5, 1, 1, 8'h00, 4'h5, 0);
        setv(20, 8'h8D, 0, 4'h0, 0, 1, 8'h00, 4'h5, 0);
        // Drop oe two cycles into settle, then a full restart
        setv(21, 8'h9E, 1, 4'h0, 0, 1, 8'h00, 4'h5, 1);
        setv(22, 8'hAF, 1, 4'h0, 0, 0, 8'h00, 4'h5, 1);
        setv(23, 8'hB0, 0, 4'h0, 0, 0, 8'h00, 4'h5, 0);
        setv(24, 8'hC1, 1, 4'h0, 0, 1, 8'h00, 4'h5, 1);
        setv(25, 8'hD2, 1, 4'h0, 0, 0, 8'h00, 4'h5, 1);
        setv(26, 8'hE3, 1, 4'h0, 0, 0, 8'h00, 4'h5, 1);
        setv(27, 8'hF4, 1, 4'h0, 0, 0, 8'h00, 4'h5, 1);
        setv(28, 8'h05, 1, 4'h0, 0, 0, 8'hFF, 4'h5, 0);

        // Reset held with live inputs
        nreset = 0; din = 8'hA5; oe = 1; cfg = '0; cfg_valid = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z", 32'(z), 32'h0);
        chk("rst_zoe", 32'(zoe), 32'h0);
        chk("rst_zcfg", 32'(zcfg), 32'(CFGRST));
        chk("rst_busy", 32'(busy), 32'h0);
        nreset = 1;

        for (int i = 0; i < 29; i++) begin
            drive_cycle(vecs[i].d, vecs[i].o, vecs[i].c, vecs[i].v);
            $display("vec %0d: in=%h oe=%b cfg=%h v=%b -> rdy=%b z=%h zoe=%h zcfg=%h busy=%b",
                     i, vecs[i].d, vecs[i].o, vecs[i].c, vecs[i].v, ready_seen, z, zoe, zcfg, busy);
            chk("vec_ready", 32'(ready_seen), 32'(vecs[i].rdy));
            chk("vec_z", 32'(z), 32'(vecs[i].d));
            chk("vec_zoe", 32'(zoe), 32'(vecs[i].e_zoe));
            chk("vec_zcfg", 32'(zcfg), 32'(vecs[i].e_zcfg));
            chk("vec_busy", 32'(busy), 32'(vecs[i].e_busy));
        end

        // Reconfigure from ON into HOLD, then async reset between edges
        drive_cycle(8'h77, 1, 4'hA, 1);
        chk("hold_busy", 32'(busy), 32'h1);
        chk("hold_zoe", 32'(zoe), 32'h0);
        #2 nreset = 0;
        #1;
        $display("async reset mid-HOLD: z=%h zoe=%h zcfg=%h busy=%b", z, zoe, zcfg, busy);
        chk("arst_z", 32'(z), 32'h0);
        chk("arst_zoe", 32'(zoe), 32'h0);
        chk("arst_zcfg", 32'(zcfg), 32'(CFGRST));
        chk("arst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            din = N'($urandom) | 8'h01;
            @(posedge clk);
            #1;
            chk("arst_z_hold", 32'(z), 32'h0);
        end
        model_reset();
        nreset = 1;

        // Randomised traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [N-1:0]    d;
            logic [CFGW-1:0] c;
            bit              o, v;
            d = N'($urandom);
            c = CFGW'($urandom);
            o = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) == 0);
            drive_cycle(d, o, c, v);
            $display("rnd %0d: in=%h oe=%b cfg=%h v=%b -> rdy=%b zoe=%h zcfg=%h busy=%b",
                     i, d, o, c, v, ready_seen, zoe, zcfg, busy);
            chk("rnd_ready", 32'(ready_seen), 32'(ready_model));
            chk("rnd_z", 32'(z), 32'(m_z));
            chk("rnd_zoe", 32'(zoe), m_driving() ? 32'hFF : 32'h0);
            chk("rnd_zcfg", 32'(zcfg), 32'(m_zcfg));
            chk("rnd_busy", 32'(busy), 32'(m_busy()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
